imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 128, instruction memory depth in 32-bit words.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  single-cycle pulse requesting a program load.
REQ-005 byte_valid  input  1  byte_data holds a valid byte this cycle.
REQ-006 byte_data  input  8  program stream byte.
REQ-007 byte_ready  output  1  loader accepts byte this cycle.
REQ-008 imem_we  output  1  instruction memory write strobe, one cycle per word.
REQ-009 imem_addr  output  32  byte address of the word being written (word-aligned, bits[1:0]=0).
REQ-010 imem_wdata  output  32  instruction word being written.
REQ-011 cpu_hold  output  1  high holds the CPU datapath in reset.
REQ-012 done  output  1  load completed successfully.
REQ-013 err  output  1  load aborted on a bad header or checksum.

Function
REQ-014 The loader SHALL be a Moore FSM with states IDLE, HDR, DATA, CHK, DONE, ERR.
REQ-015 A byte SHALL be accepted only on a cycle where byte_valid and byte_ready are both high; byte_ready SHALL be 1 in HDR, DATA and CHK, and 0 otherwise.
REQ-016 Bytes SHALL be packed big-endian: the 1st accepted byte goes to [31:24] and the 4th to [7:0]; a 2-bit byte counter SHALL wrap 3->0 on each completed word.
REQ-017 start in IDLE, DONE or ERR SHALL move the FSM to HDR next cycle and clear done, err, the word counter and the checksum; start in HDR, DATA or CHK SHALL be ignored.
REQ-018 HDR SHALL assemble one word N (word count); if 1<=N<=DEPTH, go to DATA, else go to ERR.
REQ-019 In DATA, each completed word SHALL produce imem_we=1 for exactly the next cycle, with imem_wdata=word and imem_addr={word_index,2'b00}, word_index starting at 0.
REQ-020 byte_ready SHALL remain high during the write cycle, so back-to-back bytes are never stalled.
REQ-021 After the Nth word is accepted, DATA SHALL exit to CHK when CHECKSUM is enabled, and to DONE otherwise; the Nth write strobe still SHALL occur on the following cycle.
REQ-022 word_index SHALL never exceed DEPTH-1, with no wrap-around write, which follows from REQ-018.
REQ-023 cpu_hold SHALL be 1 in every state except DONE; done=1 only in DONE; err=1 only in ERR.
REQ-024 DONE and ERR SHALL hold until start or reset; bytes presented there SHALL be ignored (not accepted).

Reset
REQ-025 reset SHALL force state=IDLE, byte counter=0, word_index=0, checksum=0, imem_we=0, imem_addr=0, imem_wdata=0, byte_ready=0, done=0, err=0, cpu_hold=1 asynchronously.
REQ-026 reset asserted mid-load SHALL abandon the load; partially written memory contents are not cleared.

Configuration
REQ-027 Macro IMEM_LOADER_CHECKSUM_EN defined: a 32-bit running sum (mod 2^32) of data words SHALL be kept; CHK SHALL assemble one word and go to DONE if it equals the sum, or to ERR otherwise; CHK produces no imem_we.
REQ-028 Macro IMEM_LOADER_CHECKSUM_EN undefined: the CHK state and the sum register SHALL be absent; err SHALL then be raised only by the header check.

Structure
REQ-029 A shared package SHALL hold the state enum typedef, the DEPTH default, and the word/byte width constants.
REQ-030 One sub-module, byte_packer (byte counter plus 32-bit shift assembly with a word_valid pulse), SHALL be used by HDR, DATA and CHK.

Verification
REQ-031 reset, start, then stream 00 00 00 02 | 8C 00 00 04 | AC 00 00 04 with valid held high -> imem_we pulses at addr 0x0 with data 0x8C000004, then at addr 0x4 with data 0xAC000004; done=1, cpu_hold=0.
REQ-032 Header N=0 or N=129 (DEPTH=128) -> ERR, err=1, no imem_we, cpu_hold=1.
REQ-033 CHECKSUM_EN defined, N=2, words 0x00000001 and 0xFFFFFFFF, check word 0x00000000 -> done=1; the same load with check word 0x00000001 -> err=1.
REQ-034 Same stream as REQ-031 with byte_valid toggling every other cycle -> identical writes and order, with no byte lost or duplicated.
REQ-035 reset asserted after 5 data bytes -> all outputs at reset values immediately; a following start and full load completes with done=1.
REQ-036 start pulsed during DATA -> ignored; the load completes normally; a start pulse in DONE restarts in HDR with cpu_hold=1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Build option: IMEM_LOADER_CHECKSUM_EN adds the trailing checksum word and the CHK state.
package imem_loader_pkg;

    localparam int WORD_W        = 32;
    localparam int BYTE_W        = 8;
    localparam int DEPTH_DEFAULT = 128;
    localparam int IDX_W         = WORD_W - 2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_DATA = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK  = 3'd3,
`endif
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Bus between a program-stream host and the loader, including the memory write port.
// Build option: none here (IMEM_LOADER_CHECKSUM_EN only changes loader internals).
interface imem_loader_if;
    import imem_loader_pkg::*;

    // Stream handshake: a byte moves on a rising edge where byte_valid && byte_ready;
    // byte_data is held while byte_valid is high and byte_ready is low.
    logic              start;
    logic              byte_valid;
    logic [BYTE_W-1:0] byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [WORD_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;

    modport slave (
        input  start, byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err
    );

    modport master (
        output start, byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Byte packer: collects four accepted bytes big-endian and flags the completing byte.
// Build option: none.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              accept_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_valid_o
);

    logic [1:0]              cnt_q;
    logic [WORD_W-BYTE_W-1:0] shift_q;

    // The completed word is presented combinationally with its last byte.
    assign word_o       = {shift_q, byte_i};
    assign word_valid_o = accept_i && (cnt_q == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= 2'd0;
            shift_q <= '0;
        end else if (clear_i) begin
            cnt_q   <= 2'd0;
            shift_q <= '0;
        end else if (accept_i) begin
            cnt_q   <= cnt_q + 2'd1;
            shift_q <= {shift_q[WORD_W-2*BYTE_W-1:0], byte_i};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed program stream into instruction memory while holding the CPU.
// Build option: IMEM_LOADER_CHECKSUM_EN appends a checksum word verified in the CHK state.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus,
    output state_e       dbg_state_o
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   word_idx_q;
    logic [WORD_W-1:0]  n_q;
    logic               imem_we_q;
    logic [WORD_W-1:0]  imem_addr_q;
    logic [WORD_W-1:0]  imem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0]  sum_q;
`endif

    logic               byte_ready_w;
    logic               cpu_hold_w;
    logic               done_w;
    logic               err_w;
    logic               accept;
    logic               restart;
    logic               last_word;
    logic [WORD_W-1:0]  word;
    logic               word_valid;

    assign accept    = bus.byte_valid && byte_ready_w;
    assign restart   = bus.start && (state_q inside {S_IDLE, S_DONE, S_ERR});
    assign last_word = ({2'b00, word_idx_q} == (n_q - 32'd1));

    imem_loader_byte_packer u_byte_packer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (restart),
        .accept_i     (accept),
        .byte_i       (bus.byte_data),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: if (bus.start) state_d = S_HDR;
            // A zero or oversized count is rejected so no write can run past DEPTH-1.
            S_HDR: if (word_valid)
                state_d = (word >= 32'd1 && word <= 32'(DEPTH)) ? S_DATA : S_ERR;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_DATA: if (word_valid && last_word) state_d = S_CHK;
            S_CHK:  if (word_valid) state_d = (word == sum_q) ? S_DONE : S_ERR;
`else
            S_DATA: if (word_valid && last_word) state_d = S_DONE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        byte_ready_w = 1'b0;
        cpu_hold_w   = 1'b1;
        done_w       = 1'b0;
        err_w        = 1'b0;
        case (state_q)
            S_HDR, S_DATA: byte_ready_w = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK:         byte_ready_w = 1'b1;
`endif
            S_DONE: begin
                cpu_hold_w = 1'b0;
                done_w     = 1'b1;
            end
            S_ERR:         err_w = 1'b1;
            default: ;
        endcase
    end

    // Write port is registered: the strobe lands the cycle after a data word completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_idx_q   <= '0;
            n_q          <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            imem_we_q <= 1'b0;
            if (restart) begin
                word_idx_q <= '0;
                n_q        <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_q      <= '0;
`endif
            end else if (state_q == S_HDR && word_valid) begin
                n_q <= word;
            end else if (state_q == S_DATA && word_valid) begin
                imem_we_q    <= 1'b1;
                imem_addr_q  <= {word_idx_q, 2'b00};
                imem_wdata_q <= word;
                word_idx_q   <= word_idx_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_q        <= sum_q + word;
`endif
            end
        end
    end

    assign bus.byte_ready = byte_ready_w;
    assign bus.cpu_hold   = cpu_hold_w;
    assign bus.done       = done_w;
    assign bus.err        = err_w;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: stream-level reference model plus directed literal checks.
// Build option: IMEM_LOADER_CHECKSUM_EN enables the checksum scenarios.
`timescale 1ns/1ps
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int DEPTH = 128;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif
    localparam int P_IDLE = 0, P_LOAD = 1, P_DONE = 2, P_ERR = 3;

    logic   clk = 1'b0;
    logic   reset;
    state_e dbg_state;
    imem_loader_if bus();

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: tracks the load as a byte count within the current stream.
    int          m_phase = P_IDLE;
    int          m_cnt   = 0;
    logic [31:0] m_acc   = '0;
    logic [31:0] m_n     = '0;
    logic [31:0] m_sum   = '0;
    bit          m_we    = 1'b0;
    logic [63:0] exp_q[$];
    logic [63:0] wr_log[$];
    logic [7:0]  sq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got timeout, expected progress", name);
    endtask

    task automatic model_step();
        int k;
        if (reset) begin
            m_phase = P_IDLE; m_cnt = 0; m_we = 1'b0; m_sum = '0;
            exp_q.delete();
            return;
        end
        m_we = 1'b0;
        if (bus.start && m_phase != P_LOAD) begin
            m_phase = P_LOAD; m_cnt = 0; m_sum = '0;
        end else if (m_phase == P_LOAD && bus.byte_valid) begin
            m_acc = {m_acc[23:0], bus.byte_data};
            m_cnt++;
            if (m_cnt % 4 == 0) begin
                k = m_cnt / 4 - 1;
                if (k == 0) begin
                    m_n = m_acc;
                    if (m_n < 1 || m_n > DEPTH) m_phase = P_ERR;
                end else if (k <= int'(m_n)) begin
                    m_we = 1'b1;
                    exp_q.push_back({32'((k - 1) * 4), m_acc});
                    m_sum = m_sum + m_acc;
                    if (k == int'(m_n)) m_phase = CK ? P_LOAD : P_DONE;
                end else begin
                    m_phase = (m_acc == m_sum) ? P_DONE : P_ERR;
                end
            end
        end
    endtask

    task automatic compare_outputs();
        chk("byte_ready", 64'(bus.byte_ready), 64'(m_phase == P_LOAD));
        chk("done",       64'(bus.done),       64'(m_phase == P_DONE));
        chk("err",        64'(bus.err),        64'(m_phase == P_ERR));
        chk("cpu_hold",   64'(bus.cpu_hold),   64'(m_phase != P_DONE));
        chk("imem_we",    64'(bus.imem_we),    64'(m_we));
        if (bus.imem_we === 1'b1) begin
            wr_log.push_back({bus.imem_addr, bus.imem_wdata});
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: got %0h, expected no write", {bus.imem_addr, bus.imem_wdata});
            end else begin
                chk("write_addr_data", {bus.imem_addr, bus.imem_wdata}, exp_q.pop_front());
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(posedge clk);
        #3;
        compare_outputs();
    end

    task automatic add_word(input logic [31:0] w);
        sq.push_back(w[31:24]); sq.push_back(w[23:16]);
        sq.push_back(w[15:8]);  sq.push_back(w[7:0]);
    endtask

    task automatic pulse_start();
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
    endtask

    // Called at a negedge; presents the queued stream, optionally with idle gaps and a stray start.
    task automatic send_stream(input int gap_mode, input int start_at, input int max_bytes);
        int g;
        for (int i = 0; i < sq.size() && i < max_bytes; i++) begin
            if ((gap_mode == 1 && i > 0) || (gap_mode == 2 && $urandom_range(0, 1) == 1)) begin
                bus.byte_valid = 1'b0;
                @(negedge clk);
            end
            bus.byte_valid = 1'b1;
            bus.byte_data  = sq[i];
            bus.start      = (i == start_at);
            g = 0;
            while (bus.byte_ready !== 1'b1 && g < 20) begin
                @(negedge clk);
                g++;
            end
            if (g >= 20) begin
                fail_now("byte_ready_wait");
                bus.byte_valid = 1'b0;
                bus.start      = 1'b0;
                return;
            end
            @(negedge clk);
            bus.start = 1'b0;
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic wait_end();
        int g = 0;
        while (!(bus.done === 1'b1 || bus.err === 1'b1) && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20) fail_now("load_end_wait");
        @(negedge clk);
    endtask

    task automatic build_load(input logic [31:0] n, input int nwords, input bit rnd, input bit bad_ck);
        logic [31:0] w, s;
        sq.delete();
        add_word(n);
        s = '0;
        for (int i = 0; i < nwords; i++) begin
            w = rnd ? $urandom() : 32'(i * 32'h0101_0101 + 32'h1000_0000);
            add_word(w);
            s = s + w;
        end
        if (CK) add_word(bad_ck ? s + 32'd1 : s);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        int n, cnt0;
        reset = 1'b1;
        bus.start = 1'b0; bus.byte_valid = 1'b0; bus.byte_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready",    64'(bus.byte_ready), 64'd0);
        chk("rst_cpu_hold", 64'(bus.cpu_hold),   64'd1);
        chk("rst_addr",     64'(bus.imem_addr),  64'd0);
        reset = 1'b0;

        // Two-word reference program.
        wr_log.delete();
        sq.delete();
        add_word(32'h0000_0002); add_word(32'h8C00_0004); add_word(32'hAC00_0004);
        if (CK) add_word(32'h3800_0008);
        pulse_start();
        send_stream(0, -1, 1000);
        wait_end();
        chk("ref_writes",   64'(wr_log.size()), 64'd2);
        chk("ref_write0",   wr_log[0], 64'h0000_0000_8C00_0004);
        chk("ref_write1",   wr_log[1], 64'h0000_0004_AC00_0004);
        chk("ref_done",     64'(bus.done),     64'd1);
        chk("ref_cpu_hold", 64'(bus.cpu_hold), 64'd0);

        // Bytes offered in DONE are not taken.
        bus.byte_valid = 1'b1; bus.byte_data = 8'hAA;
        repeat (3) @(negedge clk);
        bus.byte_valid = 1'b0;
        chk("done_hold", 64'(bus.done), 64'd1);
        chk("done_no_wr", 64'(wr_log.size()), 64'd2);

        // Bad headers.
        for (int t = 0; t < 2; t++) begin
            wr_log.delete();
            sq.delete();
            add_word(t == 0 ? 32'd0 : 32'd129);
            pulse_start();
            send_stream(0, -1, 1000);
            wait_end();
            chk("hdr_err",      64'(bus.err),       64'd1);
            chk("hdr_cpu_hold", 64'(bus.cpu_hold),  64'd1);
            chk("hdr_no_wr",    64'(wr_log.size()), 64'd0);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        for (int t = 0; t < 2; t++) begin
            sq.delete();
            add_word(32'd2); add_word(32'h0000_0001); add_word(32'hFFFF_FFFF);
            add_word(t == 0 ? 32'h0 : 32'h1);
            pulse_start();
            send_stream(0, -1, 1000);
            wait_end();
            chk("ck_done", 64'(bus.done), t == 0 ? 64'd1 : 64'd0);
            chk("ck_err",  64'(bus.err),  t == 0 ? 64'd0 : 64'd1);
        end
`endif

        // Reference program with valid toggling every other cycle.
        wr_log.delete();
        sq.delete();
        add_word(32'h0000_0002); add_word(32'h8C00_0004); add_word(32'hAC00_0004);
        if (CK) add_word(32'h3800_0008);
        pulse_start();
        send_stream(1, -1, 1000);
        wait_end();
        chk("gap_writes", 64'(wr_log.size()), 64'd2);
        chk("gap_write0", wr_log[0], 64'h0000_0000_8C00_0004);
        chk("gap_write1", wr_log[1], 64'h0000_0004_AC00_0004);

        // Reset after five data bytes, then a clean reload.
        build_load(32'd2, 2, 1'b0, 1'b0);
        pulse_start();
        send_stream(0, -1, 9);
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(bus.byte_ready), 64'd0);
        chk("mid_rst_we",    64'(bus.imem_we),    64'd0);
        chk("mid_rst_wdata", 64'(bus.imem_wdata), 64'd0);
        chk("mid_rst_hold",  64'(bus.cpu_hold),   64'd1);
        chk("mid_rst_err",   64'(bus.err),        64'd0);
        @(negedge clk);
        reset = 1'b0;
        pulse_start();
        send_stream(0, -1, 1000);
        wait_end();
        chk("after_rst_done", 64'(bus.done), 64'd1);

        // Stray start during DATA, then restart from DONE.
        build_load(32'd3, 3, 1'b1, 1'b0);
        pulse_start();
        send_stream(0, 9, 1000);
        wait_end();
        chk("stray_start_done", 64'(bus.done), 64'd1);
        pulse_start();
        chk("restart_hold",  64'(bus.cpu_hold),   64'd1);
        chk("restart_ready", 64'(bus.byte_ready), 64'd1);
        send_stream(0, -1, 1000);
        wait_end();

        // Full-depth load: last address is (DEPTH-1)*4.
        wr_log.delete();
        build_load(32'(DEPTH), DEPTH, 1'b1, 1'b0);
        pulse_start();
        send_stream(0, -1, 10000);
        wait_end();
        chk("full_writes", 64'(wr_log.size()), 64'(DEPTH));
        chk("full_last_addr", 64'(wr_log[DEPTH-1][63:32]), 64'h1FC);

        // Randomized loads.
        for (int it = 0; it < 12; it++) begin
            n = $urandom_range(0, 9);
            if (n == 0) begin
                sq.delete();
                add_word(($urandom_range(0, 1) == 0) ? 32'd0 : 32'(DEPTH + $urandom_range(1, 1000)));
            end else begin
                build_load(32'(n), n, 1'b1, $urandom_range(0, 3) == 0);
            end
            cnt0 = $urandom_range(0, 3) == 0 ? $urandom_range(0, sq.size() - 1) : -1;
            pulse_start();
            send_stream($urandom_range(0, 2), cnt0, 1000);
            wait_end();
        end

        repeat (3) @(negedge clk);
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
